// File: rtl/fxp_pkg.sv
// rtl/fxp_pkg.sv - shared sign-magnitude constants and tag type for the scheduled adder
package fxp_pkg;

  // Default operand width and the split into sign bit plus magnitude field
  localparam int FXP_BITSIZE = 16;
  localparam int FXP_MAG_W   = FXP_BITSIZE - 1;

  // Adder pipeline depth; the tag pipeline is sized from this
  localparam int FXP_LATENCY = 2;

  // Requester id field wide enough for up to 8 requesters
  localparam int FXP_ID_W = 3;

  typedef struct packed {
    logic                valid;
    logic [FXP_ID_W-1:0] id;
  } tag_t;

  // Saturated magnitude (all ones) for a magnitude field of mag_w bits
  function automatic logic [63:0] fxp_sat_mag(input int mag_w);
    return ~(64'hFFFF_FFFF_FFFF_FFFF << mag_w);
  endfunction

endpackage

// File: rtl/fixed_point_add.sv
// rtl/fixed_point_add.sv - two-stage registered sign-magnitude adder with saturation
module fixed_point_add
  import fxp_pkg::*;
#(
  parameter int BITSIZE = FXP_BITSIZE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BITSIZE-1:0] a,
  input  logic [BITSIZE-1:0] b,
  output logic [BITSIZE-1:0] result
);

  localparam int M = BITSIZE - 1;
  localparam logic [M-1:0] SAT = M'(fxp_sat_mag(M));

  logic [M-1:0] mag_a;
  logic [M-1:0] mag_b;
  logic         sign_a;
  logic         sign_b;

  assign mag_a  = a[M-1:0];
  assign mag_b  = b[M-1:0];
  assign sign_a = a[M];
  assign sign_b = b[M];

  logic         s1_same;
  logic         s1_sign;
  logic [M:0]   s1_sum;
  logic [M-1:0] s1_diff;

  // Stage 1: both candidate magnitudes and the result sign; ties on unlike signs take B's sign
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_same <= 1'b0;
      s1_sign <= 1'b0;
      s1_sum  <= '0;
      s1_diff <= '0;
    end else begin
      s1_same <= (sign_a == sign_b);
      s1_sign <= (sign_a == sign_b) ? sign_a : ((mag_a > mag_b) ? sign_a : sign_b);
      s1_sum  <= {1'b0, mag_a} + {1'b0, mag_b};
      s1_diff <= (mag_a >= mag_b) ? (mag_a - mag_b) : (mag_b - mag_a);
    end
  end

  // Stage 2: pick sum or difference, clamping a carry out of the magnitude field
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
    end else begin
      result <= {s1_sign, s1_same ? (s1_sum[M] ? SAT : s1_sum[M-1:0]) : s1_diff};
    end
  end

endmodule

// File: rtl/fixed_point_add_sched.sv
// rtl/fixed_point_add_sched.sv - round-robin scheduler sharing one pipelined adder among requesters
module fixed_point_add_sched
  import fxp_pkg::*;
#(
  parameter int BITSIZE = FXP_BITSIZE,
  parameter int NREQ    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*BITSIZE-1:0] req_a,
  input  logic [NREQ*BITSIZE-1:0] req_b,
  output logic [NREQ-1:0]         res_valid,
  output logic [BITSIZE-1:0]      res_data,
  output logic                    busy,
  output logic [15:0]             op_count
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    pending;
  logic [NREQ-1:0]    eligible;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    accept;
  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      winner;
  logic               found;
  logic               any_accept;
  int                 idx_i;
  tag_t               tag_pipe [FXP_LATENCY];
  logic [PW-1:0]      out_id;
  logic [BITSIZE-1:0] op_a;
  logic [BITSIZE-1:0] op_b;

  // A requester whose result is on the bus this cycle is free again, so it may be re-granted now
  assign eligible = req_valid & ~(pending & ~res_valid);

  // Round-robin search starting at rr_ptr, wrapping past NREQ-1
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx_i  = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx_i = int'(rr_ptr) + k;
      if (idx_i >= NREQ) idx_i = idx_i - NREQ;
      if (!found && eligible[idx_i[PW-1:0]]) begin
        found  = 1'b1;
        winner = idx_i[PW-1:0];
      end
    end
  end

  // One-hot grant for the winner of this cycle
  always_comb begin
    grant = '0;
    if (found) grant[winner] = 1'b1;
  end

  assign req_ready  = grant & {NREQ{rst_n}};
  assign accept     = req_valid & req_ready;
  assign any_accept = |accept;

  assign op_a = req_a[winner*BITSIZE +: BITSIZE];
  assign op_b = req_b[winner*BITSIZE +: BITSIZE];

  fixed_point_add #(
    .BITSIZE(BITSIZE)
  ) u_add (
    .clk   (clk),
    .rst   (~rst_n),
    .a     (op_a),
    .b     (op_b),
    .result(res_data)
  );

  // Advance the round-robin pointer past the requester just accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (any_accept) begin
      rr_ptr <= (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;
    end
  end

  // Outstanding-operation flags: a same-edge re-accept wins over the retire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~res_valid) | accept;
    end
  end

  // Owner tags travel alongside the adder stages so the result is attributed correctly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FXP_LATENCY; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= '{valid: any_accept, id: FXP_ID_W'(winner)};
      for (int i = 1; i < FXP_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign out_id = tag_pipe[FXP_LATENCY-1].id[PW-1:0];

  // Decode the last tag stage into the one-hot result owner
  always_comb begin
    res_valid = '0;
    if (tag_pipe[FXP_LATENCY-1].valid) res_valid[out_id] = 1'b1;
  end

  // Completed-operation counter, wrapping naturally at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (|res_valid) begin
      op_count <= op_count + 16'd1;
    end
  end

  assign busy = |pending;

endmodule

// File: tb/tb_fixed_point_add_sched.sv
// tb/tb_fixed_point_add_sched.sv - randomized and directed self-checking bench for the scheduled adder
module tb_fixed_point_add_sched;

  localparam int W = 16;
  localparam int N = 4;
  localparam int QD = 512;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic [N-1:0]     res_valid;
  logic [W-1:0]     res_data;
  logic             busy;
  logic [15:0]      op_count;

  always #5 clk = ~clk;

  fixed_point_add_sched #(.BITSIZE(W), .NREQ(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .res_valid(res_valid),
    .res_data (res_data),
    .busy     (busy),
    .op_count (op_count)
  );

  typedef struct {
    int          id;
    logic [15:0] res;
    int          due;
  } fl_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  bit          m_pend [N];
  int          m_rr;
  int          m_opcnt;
  fl_t         inflight [$];
  logic [31:0] op_mem [N][QD];
  int          head [N];
  int          tail [N];
  int          obs_grant_id [$];
  int          obs_grant_cyc [$];
  int          obs_rv_cyc [$];
  logic [15:0] obs_res [$];
  logic [3:0]  obs_rv_vec [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference arithmetic on signed integers
  function automatic logic [15:0] golden(input logic [15:0] a, input logic [15:0] b);
    int ma, mb, s, t;
    ma = int'(a[14:0]);
    mb = int'(b[14:0]);
    if (a[15] == b[15]) begin
      s = ma + mb;
      if (s > 32767) s = 32767;
      return {a[15], s[14:0]};
    end
    s = (a[15] ? -ma : ma) + (b[15] ? -mb : mb);
    if (s == 0) return {b[15], 15'd0};
    if (s < 0) begin
      t = -s;
      return {1'b1, t[14:0]};
    end
    return {1'b0, s[14:0]};
  endfunction

  function automatic logic [15:0] rnd_op();
    logic [14:0] m;
    case ($urandom_range(0, 4))
      0: m = 15'h7FFF;
      1: m = 15'h0000;
      2: m = 15'(16'h4000 + $urandom_range(0, 3));
      default: m = 15'($urandom);
    endcase
    return {1'($urandom_range(0, 1)), m};
  endfunction

  task automatic push(input int r, input logic [15:0] a, input logic [15:0] b);
    op_mem[r][tail[r]] = {a, b};
    tail[r]++;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (head[i] < tail[i]) begin
        req_valid[i]     = 1'b1;
        req_a[i*W +: W]  = op_mem[i][head[i]][31:16];
        req_b[i*W +: W]  = op_mem[i][head[i]][15:0];
      end else begin
        req_valid[i]     = 1'b0;
        req_a[i*W +: W]  = 16'($urandom);
        req_b[i*W +: W]  = 16'($urandom);
      end
    end
  endtask

  // One clock: check outputs at the falling edge, then advance the model after the rising edge
  task automatic cycle();
    logic [3:0]  exp_rv;
    logic [15:0] exp_data;
    logic [3:0]  exp_ready;
    bit          elig [N];
    bit          any_pend;
    int          w, i;
    @(negedge clk);
    exp_rv = '0;
    exp_data = '0;
    foreach (inflight[k]) begin
      if (inflight[k].due == cyc) begin
        exp_rv[inflight[k].id] = 1'b1;
        exp_data = inflight[k].res;
      end
    end
    for (int r = 0; r < N; r++) elig[r] = req_valid[r] && (!m_pend[r] || exp_rv[r]);
    w = -1;
    for (int k = 0; k < N; k++) begin
      i = (m_rr + k) % N;
      if (w < 0 && elig[i]) w = i;
    end
    exp_ready = (w >= 0) ? 4'(1 << w) : 4'd0;
    any_pend = 1'b0;
    for (int r = 0; r < N; r++) any_pend |= m_pend[r];
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("res_valid", 32'(res_valid), 32'(exp_rv));
    if (exp_rv != 0) chk("res_data", 32'(res_data), 32'(exp_data));
    chk("busy", 32'(busy), 32'(any_pend));
    chk("op_count", 32'(op_count), 32'(m_opcnt));
    for (int r = 0; r < N; r++) begin
      if (req_valid[r] && req_ready[r]) begin
        obs_grant_id.push_back(r);
        obs_grant_cyc.push_back(cyc);
      end
    end
    if (res_valid != 0) begin
      obs_rv_cyc.push_back(cyc);
      obs_res.push_back(res_data);
      obs_rv_vec.push_back(res_valid);
    end
    @(posedge clk);
    for (int k = inflight.size() - 1; k >= 0; k--) begin
      if (inflight[k].due == cyc) begin
        m_pend[inflight[k].id] = 1'b0;
        m_opcnt = (m_opcnt + 1) & 16'hFFFF;
        inflight.delete(k);
      end
    end
    if (w >= 0) begin
      m_pend[w] = 1'b1;
      inflight.push_back('{id: w, res: golden(op_mem[w][head[w]][31:16], op_mem[w][head[w]][15:0]), due: cyc + 2});
      m_rr = (w + 1) % N;
      head[w]++;
    end
    cyc++;
    #1 drive_inputs();
  endtask

  // Reset for one cycle with every request raised, checking the cleared state while held
  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '1;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int r = 0; r < N; r++) begin
      m_pend[r] = 1'b0;
      head[r] = 0;
      tail[r] = 0;
    end
    m_rr = 0;
    m_opcnt = 0;
    inflight.delete();
    obs_grant_id.delete();
    obs_grant_cyc.delete();
    obs_rv_cyc.delete();
    obs_res.delete();
    obs_rv_vec.delete();
    cyc++;
    drive_inputs();
  endtask

  logic [15:0] arith_tab [9][3];

  initial begin
    arith_tab[0] = '{16'h7FFF, 16'h0001, 16'h7FFF};
    arith_tab[1] = '{16'h8003, 16'h8004, 16'h8007};
    arith_tab[2] = '{16'h0005, 16'h8008, 16'h8003};
    arith_tab[3] = '{16'h0005, 16'h8005, 16'h8000};
    arith_tab[4] = '{16'h8005, 16'h0005, 16'h0000};
    arith_tab[5] = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
    arith_tab[6] = '{16'h8000, 16'h0000, 16'h0000};
    arith_tab[7] = '{16'h4000, 16'h4000, 16'h7FFF};
    arith_tab[8] = '{16'h4000, 16'h3FFF, 16'h7FFF};

    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    for (int r = 0; r < N; r++) begin
      head[r] = 0;
      tail[r] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Single request from requester 0
    push(0, 16'h0003, 16'h0004);
    drive_inputs();
    repeat (5) cycle();
    chk("single_grant", 32'(obs_grant_id[0]), 32'd0);
    chk("single_latency", 32'(obs_rv_cyc[0] - obs_grant_cyc[0]), 32'd2);
    chk("single_rv", 32'(obs_rv_vec[0]), 32'h1);
    chk("single_data", 32'(obs_res[0]), 32'h0007);
    chk("single_count", 32'(op_count), 32'd1);

    // All four requesters at once after reset
    do_reset();
    for (int r = 0; r < N; r++) push(r, rnd_op(), rnd_op());
    drive_inputs();
    repeat (8) cycle();
    chk("all4_grants", 32'(obs_grant_id.size()), 32'd4);
    chk("all4_results", 32'(obs_rv_cyc.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("all4_order%0d", k), 32'(obs_grant_id[k]), 32'(k));
      chk($sformatf("all4_gcyc%0d", k), 32'(obs_grant_cyc[k] - obs_grant_cyc[0]), 32'(k));
      chk($sformatf("all4_rcyc%0d", k), 32'(obs_rv_cyc[k] - obs_grant_cyc[0]), 32'(k + 2));
    end

    // Arithmetic corner cases streamed from requester 1
    do_reset();
    for (int k = 0; k < 9; k++) push(1, arith_tab[k][0], arith_tab[k][1]);
    drive_inputs();
    repeat (24) cycle();
    chk("arith_count", 32'(obs_res.size()), 32'd9);
    for (int k = 0; k < 9 && k < obs_res.size(); k++)
      chk($sformatf("arith%0d", k), 32'(obs_res[k]), 32'(arith_tab[k][2]));

    // Requester 0 held valid: re-granted in the cycle its result appears
    do_reset();
    for (int k = 0; k < 6; k++) push(0, rnd_op(), rnd_op());
    drive_inputs();
    repeat (16) cycle();
    chk("cont_grants", 32'(obs_grant_cyc.size()), 32'd6);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("cont_regrant%0d", k), 32'(obs_grant_cyc[k+1]), 32'(obs_rv_cyc[k]));
      chk($sformatf("cont_gap%0d", k), 32'(obs_grant_cyc[k+1] - obs_grant_cyc[k]), 32'd2);
    end

    // Reset right after an accept: that operation must never complete
    do_reset();
    push(2, 16'h0011, 16'h0022);
    drive_inputs();
    cycle();
    chk("midrst_accepted", 32'(obs_grant_id.size()), 32'd1);
    do_reset();
    repeat (6) cycle();
    chk("midrst_no_result", 32'(obs_rv_cyc.size()), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_count", 32'(op_count), 32'd0);

    // Random traffic with a reset in the middle
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c == 300) do_reset();
      for (int r = 0; r < N; r++) begin
        if ($urandom_range(0, 2) != 0 && (tail[r] - head[r]) < 2) push(r, rnd_op(), rnd_op());
      end
      drive_inputs();
      cycle();
    end
    for (int r = 0; r < N; r++) tail[r] = head[r];
    drive_inputs();
    repeat (6) cycle();
    chk("final_busy", 32'(busy), 32'd0);
    chk("final_count", 32'(op_count), 32'(m_opcnt));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
